// File: rtl/servo_motion_seq.sv
// Servo motion sequencer: per-joint targets over valid/ready, slewed toward once per PWM frame,
// with power-up homing and arm/disarm handling.
module servo_motion_seq #(
    parameter int unsigned NUM_JOINTS    = 4,
    parameter int unsigned POS_W         = 8,
    parameter int unsigned POS_MAX       = 100,
    parameter int unsigned HOME_POS      = 50,
    parameter int unsigned STEP          = 2,
    parameter int unsigned PERIOD_CYCLES = 1_000_000,
    parameter int unsigned SETTLE_FRAMES = 25
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        arm,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd_joint,
    input  logic [POS_W-1:0]            cmd_pos,
    output logic [NUM_JOINTS-1:0]       en_out,
    output logic [NUM_JOINTS*POS_W-1:0] pos_out,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        frame_tick
);

    localparam int unsigned CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int unsigned SET_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;

    localparam logic [POS_W-1:0]            HOME_V   = POS_W'(HOME_POS);
    localparam logic [POS_W-1:0]            MAX_V    = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0]            STEP_V   = POS_W'(STEP);
    localparam logic [NUM_JOINTS*POS_W-1:0] HOME_ALL = {NUM_JOINTS{HOME_V}};
    localparam logic [CNT_W-1:0]            CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [SET_W-1:0]            SET_LAST = SET_W'(SETTLE_FRAMES - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_HOME,
        S_IDLE,
        S_MOVE
    } state_e;

    state_e                             state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [SET_W-1:0]                   settle_q, settle_d;
    logic [NUM_JOINTS-1:0][POS_W-1:0]   cur_q, cur_d;
    logic [NUM_JOINTS-1:0][POS_W-1:0]   tgt_q, tgt_d;
    logic [NUM_JOINTS-1:0][POS_W-1:0]   tgt_wr, step_pos;
    logic [NUM_JOINTS-1:0]              en_q, en_d;
    logic                               done_q, done_d;
    logic                               err_q, err_d;
    logic [POS_W-1:0]                   sel_cur;
    logic                               accept, legal;

    // Clamped single-frame slew; the min() keeps the result between cur and tgt, so no wrap.
    function automatic logic [POS_W-1:0] slew(input logic [POS_W-1:0] cur,
                                              input logic [POS_W-1:0] tgt);
        logic [POS_W-1:0] diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            slew = cur + ((diff < STEP_V) ? diff : STEP_V);
        end else begin
            diff = cur - tgt;
            slew = cur - ((diff < STEP_V) ? diff : STEP_V);
        end
    endfunction

    assign frame_tick = (cnt_q == CNT_LAST);
    assign cmd_ready  = (state_q == S_IDLE) || (state_q == S_MOVE);
    assign busy       = (state_q == S_HOME) || (state_q == S_MOVE);
    assign en_out     = en_q;
    assign pos_out    = cur_q;
    assign done       = done_q;
    assign err        = err_q;

    assign accept = cmd_valid && cmd_ready;
    assign legal  = ({1'b0, cmd_joint} < 4'(NUM_JOINTS)) && (cmd_pos <= MAX_V);

    always_comb begin
        sel_cur = HOME_V;
        tgt_wr  = tgt_q;
        for (int unsigned j = 0; j < NUM_JOINTS; j++) begin
            if (cmd_joint == 3'(j)) begin
                sel_cur   = cur_q[j];
                tgt_wr[j] = cmd_pos;
            end
            step_pos[j] = slew(cur_q[j], tgt_q[j]);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = frame_tick ? '0 : cnt_q + CNT_W'(1);
        settle_d = settle_q;
        cur_d    = cur_q;
        tgt_d    = tgt_q;
        en_d     = en_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_OFF: begin
                en_d  = '0;
                cur_d = HOME_ALL;
                tgt_d = HOME_ALL;
                if (arm) begin
                    state_d  = S_HOME;
                    settle_d = '0;
                    en_d     = '1;
                end
            end
            S_HOME: begin
                en_d  = '1;
                cur_d = HOME_ALL;
                tgt_d = HOME_ALL;
                if (frame_tick) begin
                    if (settle_q == SET_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
            end
            S_IDLE: begin
                if (accept) begin
                    if (legal) begin
                        tgt_d = tgt_wr;
                        if (cmd_pos != sel_cur) begin
                            state_d = S_MOVE;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_MOVE: begin
                if (accept) begin
                    if (legal) begin
                        tgt_d = tgt_wr;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // Step uses pre-edge targets; completion compares against post-edge targets so a
                // same-edge retarget keeps the move alive.
                if (frame_tick) begin
                    cur_d = step_pos;
                    if (cur_d == tgt_d) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_OFF;
        endcase

        if (!arm) begin
            state_d = S_OFF;
            en_d    = '0;
            cur_d   = HOME_ALL;
            tgt_d   = HOME_ALL;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            settle_q <= '0;
            cur_q    <= HOME_ALL;
            tgt_q    <= HOME_ALL;
            en_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            cur_q    <= cur_d;
            tgt_q    <= tgt_d;
            en_q     <= en_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_servo_motion_seq.sv
// Scoreboard bench for servo_motion_seq: expected per-frame positions are queued after each
// accepted command and compared in the cycle following every frame tick.
`timescale 1ns/1ps
module tb_servo_motion_seq;

    localparam int unsigned NJ = 4;
    localparam int unsigned PW = 8;
    localparam int unsigned P  = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_joint;
    logic [PW-1:0] cmd_pos;
    logic [NJ-1:0] en_out;
    logic [31:0]   pos_out;
    logic          busy, done, err, frame_tick;

    typedef struct packed {
        logic [31:0] pos;
        logic        done;
    } exp_t;

    exp_t        pos_q[$];
    exp_t        e;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned done_cnt = 0;
    int unsigned err_cnt  = 0;
    int unsigned exp_done = 0;
    int unsigned err_base;
    logic        tick_prev = 1'b0;

    servo_motion_seq #(
        .NUM_JOINTS(NJ), .POS_W(PW), .POS_MAX(100), .HOME_POS(50),
        .STEP(2), .PERIOD_CYCLES(P), .SETTLE_FRAMES(3)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_joint(cmd_joint), .cmd_pos(cmd_pos), .en_out(en_out), .pos_out(pos_out),
        .busy(busy), .done(done), .err(err), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] mk(input int unsigned j0, input int unsigned j1,
                                       input int unsigned j2, input int unsigned j3);
        return {8'(j3), 8'(j2), 8'(j1), 8'(j0)};
    endfunction

    task automatic push(input logic [31:0] pos, input logic d);
        exp_t x;
        x.pos  = pos;
        x.done = d;
        pos_q.push_back(x);
    endtask

    // Scoreboard monitor: one queued entry per frame tick while entries are pending.
    always @(negedge clk) begin
        if (tick_prev && pos_q.size() > 0) begin
            e = pos_q.pop_front();
            check_val("pos_frame", pos_out, e.pos);
            check_val("done_frame", 32'(done), 32'(e.done));
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
        tick_prev = frame_tick;
    end

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic send_cmd(input int unsigned j, input int unsigned p, input logic exp_err);
        check_val("cmd_ready", 32'(cmd_ready), 1);
        cmd_joint = 3'(j);
        cmd_pos   = 8'(p);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check_val("err_pulse", 32'(err), 32'(exp_err));
    endtask

    // after=1: return #1 after the tick edge; after=0: return inside the tick cycle.
    task automatic wait_tick(input logic after);
        int unsigned n = 0;
        while (!frame_tick && n < 3 * P) begin
            @(posedge clk);
            #1 n++;
        end
        if (!frame_tick) check_val("tick_timeout", 32'(frame_tick), 1);
        if (after) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string tag);
        int unsigned n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(done), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_homing();
        wait_tick(1'b1);
        wait_tick(1'b1);
        check_val("home_not_ready", 32'(cmd_ready), 0);
        check_val("home_busy", 32'(busy), 1);
        wait_tick(1'b1);
        check_val("homed_ready", 32'(cmd_ready), 1);
        check_val("homed_busy", 32'(busy), 0);
        check_val("homed_pos", pos_out, mk(50, 50, 50, 50));
        check_val("homed_en", 32'(en_out), 32'hF);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; cmd_valid = 1'b0; cmd_joint = '0; cmd_pos = '0;
        #2;
        check_val("rst_en", 32'(en_out), 0);
        check_val("rst_ready", 32'(cmd_ready), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_done", 32'(done), 0);
        check_val("rst_err", 32'(err), 0);
        check_val("rst_tick", 32'(frame_tick), 0);
        check_val("rst_pos", pos_out, mk(50, 50, 50, 50));

        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("off_en", 32'(en_out), 0);
        check_val("off_ready", 32'(cmd_ready), 0);
        arm = 1'b1;
        @(posedge clk);
        #1;
        check_val("arm_en", 32'(en_out), 32'hF);
        check_val("arm_busy", 32'(busy), 1);
        check_val("arm_ready", 32'(cmd_ready), 0);
        do_homing();

        // Single move: joint 1 to 57
        send_cmd(1, 57, 1'b0);
        push(mk(50, 52, 50, 50), 1'b0);
        push(mk(50, 54, 50, 50), 1'b0);
        push(mk(50, 56, 50, 50), 1'b0);
        push(mk(50, 57, 50, 50), 1'b1);
        exp_done++;
        wait_done("single_done");
        check_val("single_q_empty", 32'(pos_q.size()), 0);
        check_val("single_done_cnt", done_cnt, exp_done);
        check_val("single_idle_busy", 32'(busy), 0);

        // Multi-joint with retarget of joint 0 after two frames
        wait_tick(1'b1);
        send_cmd(0, 40, 1'b0);
        push(mk(48, 57, 50, 52), 1'b0);
        push(mk(46, 57, 50, 54), 1'b0);
        push(mk(48, 57, 50, 56), 1'b0);
        push(mk(50, 57, 50, 58), 1'b0);
        push(mk(50, 57, 50, 60), 1'b1);
        exp_done++;
        send_cmd(3, 60, 1'b0);
        wait_tick(1'b1);
        wait_tick(1'b1);
        send_cmd(0, 50, 1'b0);
        wait_done("multi_done");
        check_val("multi_q_empty", 32'(pos_q.size()), 0);
        check_val("multi_done_cnt", done_cnt, exp_done);

        // Illegal commands: position too large, joint out of range
        err_base = err_cnt;
        send_cmd(2, 101, 1'b1);
        send_cmd(5, 10, 1'b1);
        @(posedge clk);
        #1;
        check_val("illegal_err_low", 32'(err), 0);
        check_val("illegal_err_cnt", err_cnt - err_base, 2);
        check_val("illegal_ready", 32'(cmd_ready), 1);
        check_val("illegal_busy", 32'(busy), 0);
        wait_tick(1'b1);
        @(negedge clk);
        check_val("illegal_pos", pos_out, mk(50, 57, 50, 60));
        check_val("illegal_still_idle", 32'(busy), 0);
        @(posedge clk);
        #1;

        // Tick collision: command accepted on the frame_tick edge
        wait_tick(1'b0);
        send_cmd(2, 70, 1'b0);
        push(mk(50, 57, 50, 60), 1'b0);
        for (int unsigned k = 1; k <= 10; k++) push(mk(50, 57, 50 + 2 * k, 60), k == 10);
        exp_done++;
        wait_done("collide_done");
        check_val("collide_q_empty", 32'(pos_q.size()), 0);
        check_val("collide_done_cnt", done_cnt, exp_done);

        // Disarm mid-move
        send_cmd(2, 50, 1'b0);
        push(mk(50, 57, 68, 60), 1'b0);
        push(mk(50, 57, 66, 60), 1'b0);
        wait_tick(1'b1);
        wait_tick(1'b1);
        arm = 1'b0;
        @(posedge clk);
        #1;
        check_val("disarm_en", 32'(en_out), 0);
        check_val("disarm_pos", pos_out, mk(50, 50, 50, 50));
        check_val("disarm_busy", 32'(busy), 0);
        check_val("disarm_ready", 32'(cmd_ready), 0);
        check_val("disarm_q_empty", 32'(pos_q.size()), 0);
        repeat (2 * P) @(posedge clk);
        #1;
        check_val("disarm_no_done", done_cnt, exp_done);
        arm = 1'b1;
        @(posedge clk);
        #1;
        check_val("rearm_en", 32'(en_out), 32'hF);
        check_val("rearm_busy", 32'(busy), 1);
        do_homing();

        // Asynchronous reset mid-move
        send_cmd(1, 80, 1'b0);
        push(mk(50, 52, 50, 50), 1'b0);
        wait_tick(1'b1);
        @(negedge clk);
        #1;
        check_val("prerst_q_empty", 32'(pos_q.size()), 0);
        check_val("prerst_busy", 32'(busy), 1);
        #1 rst = 1'b1;
        #1;
        check_val("arst_en", 32'(en_out), 0);
        check_val("arst_pos", pos_out, mk(50, 50, 50, 50));
        check_val("arst_busy", 32'(busy), 0);
        check_val("arst_ready", 32'(cmd_ready), 0);
        check_val("arst_done", 32'(done), 0);
        check_val("arst_tick", 32'(frame_tick), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/servo_motion_seq.md
Name: servo_motion_seq

Overview:
- Motion sequencer for the arm's servo PWM channels. It accepts joint position commands over a valid/ready handshake and keeps one target per joint.
- Once per PWM frame it slews each joint's current position toward its target by a bounded step, which limits servo speed.
- It drives the per-joint position/enable pairs that feed the PWM servo drivers. It also handles power-up homing and arm/disarm.

Parameters:
- NUM_JOINTS, 4, number of servo channels (1..8).
- POS_W, 8, width of position values.
- POS_MAX, 100, largest legal position.
- HOME_POS, 50, position used at power-up, homing and disarm.
- STEP, 2, maximum position change per joint per frame (≥1).
- PERIOD_CYCLES, 1_000_000, clk cycles per frame; matches the PWM period.
- SETTLE_FRAMES, 25, frames spent holding HOME_POS before accepting commands.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  level; 1 = servos powered and controlled.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_joint  in  3  joint index.
- cmd_pos  in  POS_W  requested position.
- en_out  out  NUM_JOINTS  per-joint enable to the PWM drivers.
- pos_out  out  NUM_JOINTS*POS_W  current positions; joint j occupies bits [j*POS_W +: POS_W].
- busy  out  1  1 in HOME or MOVE.
- done  out  1  one-cycle pulse when a move completes.
- err  out  1  one-cycle pulse when an illegal command is dropped.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async assert, sync release):
  - State OFF; frame counter 0.
  - All current and target positions = HOME_POS.
  - en_out=0, cmd_ready=0, busy=0, done=0, err=0, frame_tick=0.
- Frame counter:
  - Free-runs 0..PERIOD_CYCLES-1 in every state.
  - frame_tick=1 in the cycle the counter equals PERIOD_CYCLES-1, then the counter wraps to 0.
- Handshake:
  - A command is accepted when cmd_valid & cmd_ready at a posedge.
  - cmd_ready is combinational from state: 1 in IDLE and MOVE, 0 otherwise.
- Legal command (cmd_joint < NUM_JOINTS and cmd_pos ≤ POS_MAX):
  - Writes target[cmd_joint] on the accepting edge.
  - Back-to-back commands to the same joint: last one wins.
- Illegal command:
  - Still completes the handshake; no target changes.
  - err=1 in the following cycle only.
- OFF:
  - en_out=0; current and target held at HOME_POS.
  - arm=1 -> HOME; frame count for settle cleared.
- HOME:
  - en_out all 1; current = target = HOME_POS.
  - Counts frame_ticks; after the SETTLE_FRAMES-th tick -> IDLE.
- IDLE:
  - Accepting a legal command whose target differs from that joint's current -> MOVE next cycle.
  - A legal command equal to current stays in IDLE, with no done pulse.
- MOVE:
  - On each frame_tick, each joint updates: current += min(STEP, target-current) if below target; current -= min(STEP, current-target) if above; unchanged if equal.
  - The step uses targets as registered before that edge. A command accepted in the same cycle as frame_tick takes effect at the next tick.
  - If every current equals its target after the update, go to IDLE and assert done=1 for one cycle.
  - Retargeting during MOVE is allowed and simply changes the goal.
- pos_out:
  - Registered; it changes only in the cycle after a frame_tick.
  - No overshoot; arithmetic is unsigned POS_W with no wrap, guaranteed by the min() clamps.
- Disarm:
  - arm=0 in any state -> OFF on the next edge.
  - en_out falls together with that edge; current and target reset to HOME_POS.
  - The move is abandoned with no done pulse. Re-arming repeats HOME.
- Reset mid-move: immediate return to the reset values listed above.
- busy = (state==HOME || state==MOVE).

Test Plan (PERIOD_CYCLES=10, STEP=2, SETTLE_FRAMES=3, NUM_JOINTS=4):
- Power-up: release rst, arm=1 at cycle 5.
  - Required: en_out=4'hF and busy=1 on the next edge.
  - cmd_ready rises right after the 3rd frame_tick; all positions = 50.
- Single move: command joint 1 to 57 from IDLE.
  - Required: pos_out[1] steps 52, 54, 56, 57 on four consecutive frames.
  - done pulses once, in the cycle after the frame that produced 57; other joints stay at 50.
- Multi-joint plus retarget: joint 0 to 40, joint 3 to 60; after 2 frames, retarget joint 0 to 50.
  - Required: joint 0 goes 48, 46, then 48, 50; joint 3 reaches 60 after 5 frames.
  - A single done pulse occurs when the last joint settles.
- Illegal commands: cmd_pos=101 to joint 2, then cmd_joint=5.
  - Required: both handshakes complete; err pulses twice; targets unchanged; state stays IDLE.
- Tick collision: command joint 2 to 70 in the exact frame_tick cycle.
  - Required: the first change to 52 appears one frame later, not in the next cycle.
- Disarm mid-move, then rst mid-move:
  - arm=0 -> en_out=0 and positions=50 next cycle, no done pulse; re-arm repeats the 3-frame homing.
  - rst asserted asynchronously -> outputs return to reset values without waiting for clk.
